// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port synchronous memory.
// Data has priority until its streak reaches STARVE_LIMIT with a fetch waiting; responses return 1 cycle after grant.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_valid,
    output logic [31:0] dm_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    output logic        stall_if,
    output logic        stall_mem
);

    // A zero limit still needs a one-bit counter; it simply never leaves 0.
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RESP_IF    = 2'd1,
        RESP_DM_RD = 2'd2,
        RESP_DM_WR = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [SW-1:0]   r_streak;
    logic [31:0]     r_if_rdata;
    logic [31:0]     r_dm_rdata;
    logic            w_if_wins;
    logic            w_if_gnt;
    logic            w_dm_gnt;
    logic            w_if_valid;
    logic            w_dm_rd_valid;
    logic            w_dm_wr_valid;

    assign w_if_wins = if_req & (~dm_req | (r_streak == LIMIT));
    assign w_if_gnt  = ~rst & w_if_wins;
    assign w_dm_gnt  = ~rst & dm_req & ~w_if_wins;

    assign if_gnt    = w_if_gnt;
    assign dm_gnt    = w_dm_gnt;
    assign stall_if  = if_req & ~w_if_gnt;
    assign stall_mem = dm_req & ~w_dm_gnt;

    assign mem_addr  = w_if_gnt ? if_addr : (w_dm_gnt ? dm_addr : 32'd0);
    assign mem_we    = w_dm_gnt & dm_we;
    assign mem_din   = (w_if_gnt | w_dm_gnt) ? dm_wdata : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = IDLE;
        if (w_if_gnt) begin
            w_next_state = RESP_IF;
        end else if (w_dm_gnt) begin
            w_next_state = dm_we ? RESP_DM_WR : RESP_DM_RD;
        end
    end

    // A response still in flight when reset arrives is dropped here.
    always_comb begin
        w_if_valid    = 1'b0;
        w_dm_rd_valid = 1'b0;
        w_dm_wr_valid = 1'b0;
        if (!rst) begin
            case (r_state)
                RESP_IF:    w_if_valid    = 1'b1;
                RESP_DM_RD: w_dm_rd_valid = 1'b1;
                RESP_DM_WR: w_dm_wr_valid = 1'b1;
                default:    ;
            endcase
        end
    end

    assign if_valid = w_if_valid;
    assign dm_valid = w_dm_rd_valid | w_dm_wr_valid;
    assign if_rdata = w_if_valid ? mem_dout : r_if_rdata;
    assign dm_rdata = w_dm_rd_valid ? mem_dout : r_dm_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_rdata <= 32'd0;
            r_dm_rdata <= 32'd0;
        end else begin
            if (w_if_valid) begin
                r_if_rdata <= mem_dout;
            end
            if (w_dm_rd_valid) begin
                r_dm_rdata <= mem_dout;
            end
        end
    end

    // Streak only measures data grants that actually held off a waiting fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_streak <= '0;
        end else if (w_if_gnt || !if_req) begin
            r_streak <= '0;
        end else if (w_dm_gnt && (r_streak < LIMIT)) begin
            r_streak <= r_streak + SW'(1);
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: max consecutive data grants while an instruction request waits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port if_req  input  1  instruction-fetch read request.
REQ-005 SHALL have port if_addr  input  32  instruction address.
REQ-006 SHALL have port if_gnt  output  1  fetch request accepted this cycle.
REQ-007 SHALL have port if_valid  output  1  fetch data returned this cycle.
REQ-008 SHALL have port if_rdata  output  32  fetch data, held until next if_valid.
REQ-009 SHALL have port dm_req  input  1  data-memory request.
REQ-010 SHALL have port dm_we  input  1  data request is a write.
REQ-011 SHALL have port dm_addr  input  32  data address.
REQ-012 SHALL have port dm_wdata  input  32  write data.
REQ-013 SHALL have port dm_gnt  output  1  data request accepted this cycle.
REQ-014 SHALL have port dm_valid  output  1  data read returned or write acknowledged this cycle.
REQ-015 SHALL have port dm_rdata  output  32  read data, held until next read dm_valid.
REQ-016 SHALL have port mem_addr  output  32  shared single-port memory address.
REQ-017 SHALL have port mem_we  output  1  shared memory write enable.
REQ-018 SHALL have port mem_din  output  32  shared memory write data.
REQ-019 SHALL have port mem_dout  input  32  shared memory read data, valid one cycle after address.
REQ-020 SHALL have port stall_if  output  1  equals if_req & ~if_gnt.
REQ-021 SHALL have port stall_mem  output  1  equals dm_req & ~dm_gnt.

Function
REQ-022 SHALL grant at most one requester per cycle; if_gnt and dm_gnt are combinational from the current requests and state.
REQ-023 SHALL give priority to dm_req, except when streak counter == STARVE_LIMIT and if_req is high, in which case if_gnt wins.
REQ-024 SHALL, on a grant, drive mem_addr from the granted address; mem_we = dm_gnt & dm_we; mem_din = dm_wdata; with no grant, mem_we = 0 and mem_addr/mem_din = 0.
REQ-025 SHALL keep response FSM states IDLE, RESP_IF, RESP_DM_RD, RESP_DM_WR; next state = RESP_IF on if_gnt, RESP_DM_RD/RESP_DM_WR on dm_gnt by dm_we, else IDLE.
REQ-026 SHALL assert if_valid exactly in RESP_IF, capturing mem_dout into if_rdata on that edge.
REQ-027 SHALL assert dm_valid in RESP_DM_RD (capturing mem_dout into dm_rdata) and in RESP_DM_WR (dm_rdata unchanged).
REQ-028 SHALL support back-to-back grants: a new grant may issue in a cycle that is also a response cycle; latency grant-to-valid is exactly 1 cycle.
REQ-029 SHALL keep a streak counter (width clog2(STARVE_LIMIT+1)): increments on dm_gnt while if_req is high, saturates at STARVE_LIMIT, clears on if_gnt or when if_req is low.
REQ-030 SHALL treat requests as level signals: a requester drops req the cycle after gnt unless issuing a new request; requests with no gnt are retried each cycle with no state kept.
REQ-031 SHALL, with STARVE_LIMIT = 0, behave as strict fetch-priority when if_req is high.

Reset
REQ-032 SHALL, while rst is high at a clock edge, set FSM to IDLE, streak to 0, and if_rdata and dm_rdata to 0; if_valid/dm_valid are 0 the following cycle.
REQ-033 SHALL force if_gnt, dm_gnt, mem_we to 0 in any cycle rst is high; stall_if/stall_mem then equal the raw requests.
REQ-034 SHALL discard a response pending at reset (grant in cycle N, rst in cycle N+1): no valid asserted and captured data unchanged.

Verification
REQ-035 SHALL cover: if_req only, if_addr=0x100, mem_dout=0xDEADBEEF next cycle -> if_gnt same cycle, if_valid=1 and if_rdata=0xDEADBEEF one cycle later.
REQ-036 SHALL cover: if_req and dm_req (read, addr 0x2000) together -> dm_gnt=1, if_gnt=0, stall_if=1; fetch granted next cycle when dm_req drops.
REQ-037 SHALL cover: dm_we=1, addr 0x3000, wdata 0x12345678 -> mem_we=1, mem_din=0x12345678 in grant cycle; dm_valid=1 next cycle; dm_rdata unchanged.
REQ-038 SHALL cover: dm_req and if_req held high 6 cycles, STARVE_LIMIT=4 -> dm_gnt cycles 0-3, if_gnt cycle 4, dm_gnt cycle 5.
REQ-039 SHALL cover: grant fetch in cycle N, rst=1 in cycle N+1 -> if_valid stays 0, if_rdata=0, FSM IDLE.
REQ-040 SHALL cover: alternating fetch/data grants on consecutive cycles -> a valid on every cycle after the first, routed to the correct requester.
